fetch_skid_buffer: RTL and testbench
====================================

Name: fetch_skid_buffer

Overview:
- IF-stage fetch sequencer and IF/ID register with a one-entry skid buffer, sitting between the synchronous instruction memory and the ID stage.
- Consumes the load-use Stall from the hazard logic and the EX-stage branch/jump Flush.
- Freezes fetch without losing the instruction already in flight in the 1-cycle-latency IMEM, then resumes without bubbles.
- Keeps stall and flush cycle counters for performance debug.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, instruction held in ID_Instr when ID_Valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Stall  input  1  load-use stall: hold ID, stop issuing fetches.
- Flush  input  1  redirect from EX; has priority over Stall.
- Redirect_PC  input  XLEN  target address when Flush=1.
- IMEM_addr  output  XLEN  fetch address, equal to the PC register.
- IMEM_en  output  1  fetch issue strobe, combinational: !Stall && !Flush.
- IMEM_rdata  input  32  instruction for the address issued in the previous cycle.
- ID_Instr  output  32  IF/ID instruction register.
- ID_PC  output  XLEN  IF/ID PC register.
- ID_Valid  output  1  IF/ID contents are a real instruction.
- StallCount  output  32  number of cycles with Stall=1 and Flush=0.
- FlushCount  output  32  number of cycles with Flush=1.

Behaviour:
Reset (asynchronous, active-high) sets:
- PC = RESET_PC.
- pend_valid = 0, skid_valid = 0.
- ID_Valid = 0, ID_Instr = NOP, ID_PC = 0.
- Both counters = 0.
- The first issue is RESET_PC in the first cycle after reset deasserts.

Internal state:
- pend_valid / pend_pc: a fetch was issued last cycle, so IMEM_rdata is meaningful this cycle.
- skid_valid / skid_instr / skid_pc: the one-entry skid buffer.

Priority each cycle is Flush, then Stall, then advance.

Flush:
- PC <= {Redirect_PC[XLEN-1:2], 2'b00}.
- pend_valid <= 0, skid_valid <= 0; the in-flight IMEM_rdata is discarded.
- ID_Valid <= 0, ID_Instr <= NOP.
- No issue this cycle. The first fetch of the target happens the next cycle, so the target reaches ID two cycles after the Flush cycle.

Stall (Flush=0):
- ID registers hold.
- PC holds, and no issue is made.
- If pend_valid=1, then skid <= {IMEM_rdata, pend_pc} and skid_valid <= 1.
- pend_valid <= 0.
- A stall lasting several cycles captures only in the first cycle; later cycles change nothing except StallCount.

Advance (Stall=0, Flush=0):
- If skid_valid=1, ID <= skid contents with ID_Valid=1, and skid_valid <= 0.
- Otherwise, ID <= {IMEM_rdata, pend_pc} with ID_Valid <= pend_valid; when pend_valid=0, ID_Instr <= NOP.
- Always: issue at PC, pend_pc <= PC, pend_valid <= 1, PC <= PC + 4.

Invariants:
- At most one fetch is ever in flight.
- skid_valid and pend_valid are never both 1 on an advance cycle, so one skid entry is sufficient and no instruction is lost or duplicated.

Arithmetic:
- PC + 4 wraps modulo 2^XLEN; 32'hFFFF_FFFC is followed by 0.
- Counters saturate at 32'hFFFF_FFFF.

Simultaneous and boundary cases:
- Stall and Flush together: Flush semantics apply, and only FlushCount increments.
- Stall in the first cycle after reset: nothing is captured, because pend_valid=0.
- Reset mid-stall: everything clears, and fetch restarts at RESET_PC.

Test Plan:
1. Reset, RESET_PC=0, IMEM returns mem[addr/4]=addr|0xA000, no stall -> ID_Valid first 1 in cycle 2 with ID_PC=0 and ID_Instr=0xA000, then ID_PC 4, 8, 12 on consecutive cycles with no gaps.
2. Steady stream, Stall=1 for 3 cycles while ID_PC=8 -> ID holds PC 8 for the 3 cycles, PC 12 is captured in the skid, then ID shows 12, 16, 20 on the following consecutive cycles; StallCount=3.
3. Flush with Redirect_PC=0x100 while ID_PC=0x20 -> next cycle ID_Valid=0 and ID_Instr=0x13; ID_PC=0x100 two cycles after the Flush cycle; FlushCount=1; no instruction from 0x24 or 0x28 ever reaches ID.
4. Stall=1 and Flush=1 in the same cycle with Redirect_PC=0x40, skid occupied -> skid is discarded, ID shows 0x40 two cycles later, StallCount unchanged, FlushCount increments.
5. Redirect_PC=0x103 -> IMEM_addr=0x100; RESET_PC=0xFFFF_FFFC -> the second fetch address is 0x0000_0000.
6. rst asserted asynchronously mid-stall with skid_valid=1 -> immediately ID_Valid=0, ID_Instr=0x13, counters 0, IMEM_addr=RESET_PC; after release the stream restarts cleanly from RESET_PC.

Source files
------------

// File: rtl/fetch_skid_buffer.sv
// IF-stage fetch sequencer and IF/ID register with a one-entry skid buffer.
// Stall freezes fetch while the in-flight IMEM word is parked in the skid; Flush redirects.
module fetch_skid_buffer #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Stall,
   input  logic            Flush,
   input  logic [XLEN-1:0] Redirect_PC,
   output logic [XLEN-1:0] IMEM_addr,
   output logic            IMEM_en,
   input  logic [31:0]     IMEM_rdata,
   output logic [31:0]     ID_Instr,
   output logic [XLEN-1:0] ID_PC,
   output logic            ID_Valid,
   output logic [31:0]     StallCount,
   output logic [31:0]     FlushCount
);

   localparam int unsigned ILEN = 32;
   localparam int unsigned CW   = 32;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            pend_valid_q, pend_valid_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            skid_valid_q, skid_valid_d;
   fetch_entry_t    skid_q, skid_d;
   fetch_entry_t    id_q, id_d;
   logic            id_valid_q, id_valid_d;
   logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

   // Redirect targets are word aligned; the low address bits are ignored.
   logic [1:0] unused_redirect_lsb;
   assign unused_redirect_lsb = Redirect_PC[1:0];

   // Sequencer: Flush beats Stall beats advance.
   always_comb begin
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      id_d         = id_q;
      id_valid_d   = id_valid_q;

      if (Flush) begin
         pc_d         = {Redirect_PC[XLEN-1:2], 2'b00};
         pend_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         id_valid_d   = 1'b0;
         id_d.instr   = NOP;
      end else if (Stall) begin
         if (pend_valid_q) begin
            skid_d.instr = IMEM_rdata;
            skid_d.pc    = pend_pc_q;
            skid_valid_d = 1'b1;
         end
         pend_valid_d = 1'b0;
      end else begin
         if (skid_valid_q) begin
            id_d         = skid_q;
            id_valid_d   = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            id_d.pc    = pend_pc_q;
            id_d.instr = pend_valid_q ? IMEM_rdata : NOP;
            id_valid_d = pend_valid_q;
         end
         pend_pc_d    = pc_q;
         pend_valid_d = 1'b1;
         pc_d         = pc_q + XLEN'(4);
      end
   end

   // Saturating performance counters; a combined Stall+Flush counts as a flush only.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Flush) begin
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CW'(1);
      end else if (Stall) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         id_q.instr   <= NOP;
         id_q.pc      <= '0;
         id_valid_q   <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         id_q         <= id_d;
         id_valid_q   <= id_valid_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign IMEM_addr  = pc_q;
   assign IMEM_en    = !Stall && !Flush;
   assign ID_Instr   = id_q.instr;
   assign ID_PC      = id_q.pc;
   assign ID_Valid   = id_valid_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_skid_buffer.sv
// Bench for fetch_skid_buffer: queue-based fetch model, directed scenarios, random stall/flush traffic.
module tb_fetch_skid_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        Stall;
   logic        Flush;
   logic [31:0] Redirect_PC;
   logic [31:0] IMEM_addr;
   logic        IMEM_en;
   logic [31:0] IMEM_rdata;
   logic [31:0] ID_Instr;
   logic [31:0] ID_PC;
   logic        ID_Valid;
   logic [31:0] StallCount;
   logic [31:0] FlushCount;

   logic [31:0] wrap_addr;
   logic        wrap_unused_en;
   logic [31:0] wrap_unused_instr;
   logic [31:0] wrap_unused_pc;
   logic        wrap_unused_valid;
   logic [31:0] wrap_unused_sc;
   logic [31:0] wrap_unused_fc;

   int n_checks;
   int n_errors;

   fetch_skid_buffer u_dut (
      .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Redirect_PC(Redirect_PC),
      .IMEM_addr(IMEM_addr), .IMEM_en(IMEM_en), .IMEM_rdata(IMEM_rdata),
      .ID_Instr(ID_Instr), .ID_PC(ID_PC), .ID_Valid(ID_Valid),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   fetch_skid_buffer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .Stall(1'b0), .Flush(1'b0), .Redirect_PC(32'h0),
      .IMEM_addr(wrap_addr), .IMEM_en(wrap_unused_en), .IMEM_rdata(32'h0),
      .ID_Instr(wrap_unused_instr), .ID_PC(wrap_unused_pc), .ID_Valid(wrap_unused_valid),
      .StallCount(wrap_unused_sc), .FlushCount(wrap_unused_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a | 32'h0000_A000;
   endfunction

   // Synchronous IMEM; a cycle without a read returns garbage so stale data is exposed.
   always @(posedge clk) begin
      if (IMEM_en) IMEM_rdata <= mem_f(IMEM_addr);
      else         IMEM_rdata <= $urandom;
   end

   // Reference: fetched-but-undelivered addresses live in a FIFO.
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic        m_id_valid;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic [31:0] m_sc;
   logic [31:0] m_fc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_q.delete();
         m_id_valid = 1'b0; m_id_pc = 32'h0; m_id_instr = NOP;
         m_sc = 32'h0; m_fc = 32'h0;
      end else if (Flush) begin
         m_pc = Redirect_PC & 32'hFFFF_FFFC;
         m_q.delete();
         m_id_valid = 1'b0; m_id_instr = NOP;
         if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
      end else if (Stall) begin
         if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
      end else begin
         if (m_q.size() > 0) begin
            m_id_pc = m_q.pop_front();
            m_id_valid = 1'b1;
            m_id_instr = mem_f(m_id_pc);
         end else begin
            m_id_valid = 1'b0;
            m_id_instr = NOP;
         end
         m_q.push_back(m_pc);
         m_pc = m_pc + 32'd4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("imem_addr", IMEM_addr, m_pc);
      chk("imem_en", 32'(IMEM_en), 32'(!Stall && !Flush));
      chk("id_valid", 32'(ID_Valid), 32'(m_id_valid));
      chk("id_instr", ID_Instr, m_id_instr);
      if (m_id_valid) chk("id_pc", ID_PC, m_id_pc);
      chk("stall_count", StallCount, m_sc);
      chk("flush_count", FlushCount, m_fc);
   endtask

   // Drive one cycle's inputs, compare mid-cycle, return just after the next rising edge.
   task automatic cycle(input logic s, input logic f, input logic [31:0] r);
      Stall = s; Flush = f; Redirect_PC = r;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_id(input string name, input logic [31:0] pc);
      chk({name, "_valid"}, 32'(ID_Valid), 32'd1);
      chk({name, "_pc"}, ID_PC, pc);
      chk({name, "_instr"}, ID_Instr, mem_f(pc));
   endtask

   logic [31:0] sc_before;

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1; Stall = 1'b0; Flush = 1'b0; Redirect_PC = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_id_valid", 32'(ID_Valid), 32'd0);
      chk("rst_id_instr", ID_Instr, NOP);
      chk("rst_id_pc", ID_PC, 32'h0);
      chk("rst_counts", StallCount | FlushCount, 32'h0);
      chk("rst_addr", IMEM_addr, 32'h0);
      chk("wrap_first_addr", wrap_addr, 32'hFFFF_FFFC);
      rst = 1'b0;

      // Stream start: first valid ID two edges after reset release.
      cycle(1'b0, 1'b0, 32'h0);
      chk("wrap_second_addr", wrap_addr, 32'h0000_0000);
      chk("start_bubble", 32'(ID_Valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("s0", 32'h0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("s4", 32'h4);
      cycle(1'b0, 1'b0, 32'h0); expect_id("s8", 32'h8);

      // Three-cycle stall while ID holds PC 8, then gapless resume from the skid.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 32'h0); expect_id("stall_hold", 32'h8);
      end
      chk("stall_count3", StallCount, 32'd3);
      cycle(1'b0, 1'b0, 32'h0); expect_id("resume12", 32'hC);
      cycle(1'b0, 1'b0, 32'h0); expect_id("resume16", 32'h10);
      cycle(1'b0, 1'b0, 32'h0); expect_id("resume20", 32'h14);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
      expect_id("pre_flush", 32'h20);

      // Flush to 0x100.
      cycle(1'b0, 1'b1, 32'h100);
      chk("flush_valid", 32'(ID_Valid), 32'd0);
      chk("flush_instr", ID_Instr, NOP);
      chk("flush_count1", FlushCount, 32'd1);
      chk("flush_addr", IMEM_addr, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      chk("flush_bubble2", 32'(ID_Valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("target", 32'h100);

      // Stall+Flush with an occupied skid.
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      sc_before = StallCount;
      cycle(1'b1, 1'b1, 32'h40);
      chk("sf_stall_cnt", StallCount, sc_before);
      chk("sf_flush_cnt", FlushCount, 32'd2);
      chk("sf_valid", 32'(ID_Valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("sf_target", 32'h40);

      // Misaligned redirect.
      cycle(1'b0, 1'b1, 32'h103);
      chk("align_addr", IMEM_addr, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("align_target", 32'h100);

      // Asynchronous reset mid-stall with the skid occupied.
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      Stall = 1'b1;
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(ID_Valid), 32'd0);
      chk("arst_instr", ID_Instr, NOP);
      chk("arst_counts", StallCount | FlushCount, 32'h0);
      chk("arst_addr", IMEM_addr, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b0, 1'b0, 32'h0);
      chk("arst_bubble", 32'(ID_Valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("arst_s0", 32'h0);
      cycle(1'b0, 1'b0, 32'h0); expect_id("arst_s4", 32'h4);

      // Random stall/flush traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
